mem_io_responder: RTL and testbench

- Memory-side responder for the byte-serial memory interface driven by the core's memory controller.
- Contains byte-wide main RAM with 1-cycle read latency.
- Decodes the IO window (addr[17:16]==2'b11): byte stores to 0x30000 enter a TX FIFO drained by a UART transmitter; byte loads from 0x30000 pop an RX byte; a store to 0x30004 raises halt.
- Drives io_buffer_full back to the controller as store back-pressure.

---
 rtl/mem_io_responder_pkg.sv | 24 ++
 rtl/mem_io_responder_byte_fifo.sv | 51 +++++
 rtl/mem_io_responder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_mem_io_responder.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the memory/IO responder: IO window addresses and UART states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_io_responder_pkg;

    // Byte-wide UART data port and the halt trigger address
    localparam logic [31:0] IO_BASE   = 32'h0003_0000;
    localparam logic [31:0] IO_HALT   = 32'h0003_0004;

    // addr[17:16] value that selects the IO window instead of RAM
    localparam logic [1:0]  IO_REGION = 2'b11;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    function automatic logic is_io_region(input logic [31:0] addr);
        return addr[17:16] == IO_REGION;
    endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Generic synchronous byte FIFO, 2^AW entries, show-ahead read port.
// Latency: pushed byte visible at o_pop_dat the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; caller watches o_full/o_empty.
module byte_fifo
    import mem_io_responder_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [7:0]    i_push_dat,
    input  logic          i_pop,
    output logic [7:0]    o_pop_dat,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    logic [7:0]  r_mem [2**AW];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_push_ok;
    logic        w_pop_ok;

    // Extra pointer MSB distinguishes full from empty when the index bits match
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Pointer update; simultaneous push and pop keeps the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: byte RAM, UART TX FIFO + transmitter, RX byte port (IO_RX_EN), halt flag.
// Latency: mem_dout valid one cycle after the address; UART frame starts one cycle after a byte is queued.
// Backpressure: io_buffer_full (registered) rises with <=1 free TX slot; stores into a full FIFO are dropped and flagged.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_AW       = 17,
    parameter int FIFO_AW      = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic        io_buffer_full,
    output logic        uart_txd,
    input  logic        io_in_valid,
    input  logic [7:0]  io_in_data,
    output logic        io_in_ready,
    output logic        halt,
    output logic        tx_overflow
);

    localparam int                CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]     CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]  FIFO_DEPTH = (FIFO_AW + 1)'(2 ** FIFO_AW);

    // ---------------- address decode ----------------
    logic              w_io;
    logic              w_ram_we;
    logic              w_tx_push;
    logic              w_halt_set;
    logic              w_io_load_base;
    logic [RAM_AW-1:0] w_ram_idx;

    assign w_io           = is_io_region(mem_a);
    assign w_ram_we       = rdy && mem_wr && !w_io;
    assign w_tx_push      = rdy && mem_wr && (mem_a == IO_BASE);
    assign w_halt_set     = rdy && mem_wr && (mem_a == IO_HALT);
    assign w_io_load_base = !mem_wr && (mem_a == IO_BASE);
    assign w_ram_idx      = mem_a[RAM_AW-1:0];

    // ---------------- main RAM ----------------
    logic [7:0] r_ram [2**RAM_AW];
    logic [7:0] r_ram_q;

    // Synchronous write with registered read; a colliding read sees the old byte
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (w_ram_we) r_ram[w_ram_idx] <= mem_din;
            r_ram_q <= r_ram[w_ram_idx];
        end
    end

    // ---------------- TX FIFO ----------------
    logic             w_tx_full;
    logic             w_tx_empty;
    logic             w_tx_pop;
    logic             w_uart_pop;
    logic [7:0]       w_tx_dat;
    logic [FIFO_AW:0] w_tx_count;
    logic [FIFO_AW:0] w_tx_free;

    assign w_tx_pop  = rdy && w_uart_pop;
    assign w_tx_free = FIFO_DEPTH - w_tx_count;

    byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_tx_push),
        .i_push_dat (mem_din),
        .i_pop      (w_tx_pop),
        .o_pop_dat  (w_tx_dat),
        .o_full     (w_tx_full),
        .o_empty    (w_tx_empty),
        .o_count    (w_tx_count)
    );

    // ---------------- RX path / IO read data ----------------
    logic [7:0] w_io_rd_dat;

`ifdef IO_RX_EN
    logic             w_rx_full;
    logic             w_rx_empty;
    logic             w_rx_push;
    logic             w_rx_pop;
    logic             w_access_new;
    logic [7:0]       w_rx_dat;
    logic [7:0]       w_rx_byte;
    logic [FIFO_AW:0] w_unused_rx_count;
    logic [31:0]      r_prev_a;
    logic             r_prev_wr;
    logic [7:0]       r_rx_hold;

    assign io_in_ready  = !w_rx_full;
    assign w_rx_push    = rdy && io_in_valid && io_in_ready;
    // Only the first cycle of a 0x30000 load pops; held-address cycles replay r_rx_hold
    assign w_access_new = (mem_a != r_prev_a) || (mem_wr != r_prev_wr);
    assign w_rx_pop     = rdy && w_io_load_base && w_access_new;
    assign w_rx_byte    = w_rx_empty ? 8'h00 : w_rx_dat;

    byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_rx_push),
        .i_push_dat (io_in_data),
        .i_pop      (w_rx_pop),
        .o_pop_dat  (w_rx_dat),
        .o_full     (w_rx_full),
        .o_empty    (w_rx_empty),
        .o_count    (w_unused_rx_count)
    );

    // Track the previous access and keep the byte returned by the last pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_a  <= '0;
            r_prev_wr <= 1'b0;
            r_rx_hold <= 8'h00;
        end else if (rdy) begin
            r_prev_a  <= mem_a;
            r_prev_wr <= mem_wr;
            if (w_rx_pop) r_rx_hold <= w_rx_byte;
        end
    end

    // IO load data: popped/held RX byte at 0x30000, zero elsewhere
    always_comb begin
        w_io_rd_dat = 8'h00;
        if (w_io_load_base) w_io_rd_dat = w_access_new ? w_rx_byte : r_rx_hold;
    end
`else
    logic w_unused_rx;

    assign io_in_ready = 1'b0;
    assign w_unused_rx = &{1'b0, io_in_valid, io_in_data, w_io_load_base};

    // Without the RX port every IO load reads zero
    always_comb begin
        w_io_rd_dat = 8'h00;
    end
`endif

    // ---------------- read data select and status flags ----------------
    logic       r_sel_ram;
    logic [7:0] r_io_dat;
    logic       r_buf_full;
    logic       r_tx_ovf;
    logic       r_halt;

    assign mem_dout       = r_sel_ram ? r_ram_q : r_io_dat;
    assign io_buffer_full = r_buf_full;
    assign tx_overflow    = r_tx_ovf;
    assign halt           = r_halt;

    // Registered read source select plus sticky halt/overflow and the nearly-full flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_ram  <= 1'b0;
            r_io_dat   <= 8'h00;
            r_buf_full <= 1'b0;
            r_tx_ovf   <= 1'b0;
            r_halt     <= 1'b0;
        end else if (rdy) begin
            r_sel_ram  <= !w_io;
            r_io_dat   <= w_io_rd_dat;
            r_buf_full <= (w_tx_free <= (FIFO_AW + 1)'(1));
            if (w_tx_push && w_tx_full) r_tx_ovf <= 1'b1;
            if (w_halt_set)             r_halt   <= 1'b1;
        end
    end

    // ---------------- UART transmitter ----------------
    uart_state_t   r_state;
    uart_state_t   w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          r_txd;
    logic          w_txd_nxt;
    logic          w_bit_end;

    assign w_bit_end = (r_cnt == CNT_LAST);
    assign uart_txd  = r_txd;

    // Transmitter state register; txd is registered from the next state so it idles high out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= UART_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= 8'h00;
            r_txd   <= 1'b1;
        end else if (rdy) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    // Next-state: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT cycles each
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_uart_pop  = 1'b0;
        w_txd_nxt   = 1'b1;
        case (r_state)
            UART_IDLE: begin
                if (!w_tx_empty) begin
                    w_uart_pop  = 1'b1;
                    w_shift_nxt = w_tx_dat;
                    w_cnt_nxt   = '0;
                    w_state_nxt = UART_START;
                end
            end
            UART_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = UART_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            UART_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_idx == 3'd7) w_state_nxt = UART_STOP;
                    else               w_idx_nxt   = r_idx + 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            UART_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = UART_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = UART_IDLE;
            end
        endcase
        case (w_state_nxt)
            UART_START: w_txd_nxt = 1'b0;
            UART_DATA:  w_txd_nxt = w_shift_nxt[w_idx_nxt];
            default:    w_txd_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: RAM, UART framing, back-pressure, RX port, rdy freeze, halt/reset.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: expected FIFO occupancy and byte order come from queue models in the bench.
module tb_mem_io_responder;

    localparam int          CPB     = 4;
    localparam logic [31:0] A_BASE  = 32'h0003_0000;
    localparam logic [31:0] A_HALT  = 32'h0003_0004;
    localparam logic [31:0] A_OTHER = 32'h0003_0008;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        io_buffer_full;
    logic        uart_txd;
    logic        io_in_valid;
    logic [7:0]  io_in_data;
    logic        io_in_ready;
    logic        halt;
    logic        tx_overflow;

    int checks   = 0;
    int failures = 0;

    mem_io_responder #(.RAM_AW(17), .FIFO_AW(4), .CLKS_PER_BIT(CPB)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .io_buffer_full (io_buffer_full),
        .uart_txd       (uart_txd),
        .io_in_valid    (io_in_valid),
        .io_in_data     (io_in_data),
        .io_in_ready    (io_in_ready),
        .halt           (halt),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [7:0] d);
        mem_a   = a;
        mem_wr  = 1'b1;
        mem_din = d;
        tick();
        mem_wr  = 1'b0;
        mem_a   = 32'h0;
    endtask

    // Expected txd level at offset i of a frame carrying byte b
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i < CPB)           return 1'b0;
        else if (i < 9 * CPB)  return b[(i / CPB) - 1];
        else                   return 1'b1;
    endfunction

    task automatic wait_txd_low(input int max, output int gap, output bit found);
        gap   = 0;
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (uart_txd === 1'b0) begin
                found = 1'b1;
                break;
            end
            gap++;
            tick();
        end
    endtask

    // Mid-bit sampling receiver; returns at the idle cycle after the stop bit
    task automatic uart_rx(output logic [7:0] b, output bit found, output logic stop_lvl);
        int gap;
        b        = 8'h00;
        stop_lvl = 1'b0;
        wait_txd_low(2000, gap, found);
        if (found) begin
            repeat (CPB + CPB / 2) tick();
            b[0] = uart_txd;
            for (int i = 1; i < 8; i++) begin
                repeat (CPB) tick();
                b[i] = uart_txd;
            end
            repeat (CPB) tick();
            stop_lvl = uart_txd;
            repeat (CPB / 2) tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; mem_a = 32'h0; mem_wr = 1'b0; mem_din = 8'h00;
        io_in_valid = 1'b0; io_in_data = 8'h00;
        repeat (3) tick();
        checks++; if (mem_dout !== 8'h00) begin failures++; $display("FAIL reset_mem_dout got=%h exp=00", mem_dout); end
        checks++; if (io_buffer_full !== 1'b0) begin failures++; $display("FAIL reset_buf_full got=%b exp=0", io_buffer_full); end
        checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b exp=1", uart_txd); end
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", halt); end
        checks++; if (tx_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", tx_overflow); end
`ifdef IO_RX_EN
        checks++; if (io_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", io_in_ready); end
`else
        checks++; if (io_in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", io_in_ready); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ram();
        logic [7:0]  model [int];
        logic [31:0] a;
        logic [7:0]  d;
        store(32'h100 + 32'h1, 8'h5A); model[32'h101] = 8'h5A;
        store(32'h100, 8'hA5);         model[32'h100] = 8'hA5;
        mem_a = 32'h100; tick();
        checks++; if (mem_dout !== 8'hA5) begin failures++; $display("FAIL ram_latency got=%h exp=a5", mem_dout); end
        mem_a = 32'h101; tick();
        checks++; if (mem_dout !== 8'h5A) begin failures++; $display("FAIL ram_neighbour got=%h exp=5a", mem_dout); end
        for (int i = 0; i < 12; i++) begin
            a = 32'($urandom_range(32'h2FFFF, 0));
            d = 8'($urandom);
            store(a, d);
            model[int'(a)] = d;
        end
        foreach (model[k]) begin
            mem_a = 32'(k); tick();
            checks++; if (mem_dout !== model[k]) begin failures++; $display("FAIL ram_readback addr=%h got=%h exp=%h", k, mem_dout, model[k]); end
        end
        // Read-during-write returns the previous byte, next read the new one
        d = ~model[32'h100];
        mem_a = 32'h100; mem_wr = 1'b1; mem_din = d; tick(); mem_wr = 1'b0;
        checks++; if (mem_dout !== model[32'h100]) begin failures++; $display("FAIL ram_rdw_old got=%h exp=%h", mem_dout, model[32'h100]); end
        model[32'h100] = d;
        tick();
        checks++; if (mem_dout !== d) begin failures++; $display("FAIL ram_rdw_new got=%h exp=%h", mem_dout, d); end
        mem_a = 32'h0;
    endtask

    task automatic test_uart_frame();
        logic [7:0] b [2];
        int  gap;
        bit  found;
        b[0] = 8'h41;
        b[1] = 8'($urandom);
        store(A_BASE, b[0]);
        store(A_BASE, b[1]);
        for (int f = 0; f < 2; f++) begin
            wait_txd_low(10, gap, found);
            checks++; if (!found || gap > 1) begin failures++; $display("FAIL uart_gap frame=%0d found=%0d idle_cycles=%0d exp<=1", f, found, gap); end
            for (int i = 0; i < 10 * CPB; i++) begin
                checks++;
                if (uart_txd !== frame_bit(b[f], i)) begin
                    failures++;
                    $display("FAIL uart_frame frame=%0d offset=%0d got=%b exp=%b", f, i, uart_txd, frame_bit(b[f], i));
                end
                tick();
            end
        end
    endtask

    task automatic test_rdy_freeze();
        logic [7:0] b;
        int  gap;
        bit  found;
        bit  saw_low;
        b = 8'($urandom);
        store(A_BASE, b);
        wait_txd_low(10, gap, found);
        checks++; if (!found) begin failures++; $display("FAIL freeze_start got=no_start exp=start"); end
        for (int i = 0; i < 10 * CPB; i++) begin
            if (i == 13) begin
                rdy = 1'b0; mem_a = A_BASE; mem_wr = 1'b1; mem_din = 8'($urandom);
                for (int j = 0; j < 10; j++) begin
                    tick();
                    checks++;
                    if (uart_txd !== frame_bit(b, i)) begin
                        failures++;
                        $display("FAIL freeze_hold cycle=%0d got=%b exp=%b", j, uart_txd, frame_bit(b, i));
                    end
                end
                rdy = 1'b1; mem_wr = 1'b0; mem_a = 32'h0;
            end
            checks++;
            if (uart_txd !== frame_bit(b, i)) begin
                failures++;
                $display("FAIL freeze_frame offset=%0d got=%b exp=%b", i, uart_txd, frame_bit(b, i));
            end
            tick();
        end
        saw_low = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (uart_txd !== 1'b1) saw_low = 1'b1;
            tick();
        end
        checks++; if (saw_low) begin failures++; $display("FAIL freeze_store_dropped got=extra_frame exp=idle"); end
    endtask

`ifdef IO_RX_EN
    task automatic test_rx();
        logic [7:0] q [$];
        logic [7:0] d;
        logic [7:0] e;
        io_in_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            d = (k == 0) ? 8'h37 : 8'($urandom);
            io_in_data = d;
            checks++;
            if (io_in_ready !== (q.size() < 16)) begin
                failures++;
                $display("FAIL rx_ready k=%0d got=%b exp=%b", k, io_in_ready, (q.size() < 16));
            end
            tick();
            if (q.size() < 16) q.push_back(d);
        end
        io_in_valid = 1'b0;
        e = q.pop_front();
        mem_a = A_BASE; mem_wr = 1'b0;
        for (int r = 0; r < 3; r++) begin
            tick();
            checks++; if (mem_dout !== e) begin failures++; $display("FAIL rx_held cycle=%0d got=%h exp=%h", r, mem_dout, e); end
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            mem_a = 32'h0; tick();
            mem_a = A_BASE; tick();
            checks++; if (mem_dout !== e) begin failures++; $display("FAIL rx_order got=%h exp=%h", mem_dout, e); end
        end
        mem_a = 32'h0; tick();
        mem_a = A_BASE; tick();
        checks++; if (mem_dout !== 8'h00) begin failures++; $display("FAIL rx_empty got=%h exp=00", mem_dout); end
        mem_a = A_OTHER; tick();
        checks++; if (mem_dout !== 8'h00) begin failures++; $display("FAIL io_other_load got=%h exp=00", mem_dout); end
        mem_a = 32'h0;
    endtask
`else
    task automatic test_rx();
        io_in_valid = 1'b1; io_in_data = 8'h37;
        tick();
        checks++; if (io_in_ready !== 1'b0) begin failures++; $display("FAIL rx_absent_ready got=%b exp=0", io_in_ready); end
        io_in_valid = 1'b0;
        mem_a = A_BASE; mem_wr = 1'b0;
        for (int r = 0; r < 3; r++) begin
            tick();
            checks++; if (mem_dout !== 8'h00) begin failures++; $display("FAIL rx_absent_load cycle=%0d got=%h exp=00", r, mem_dout); end
        end
        mem_a = A_OTHER; tick();
        checks++; if (mem_dout !== 8'h00) begin failures++; $display("FAIL io_other_load got=%h exp=00", mem_dout); end
        mem_a = 32'h0;
    endtask
`endif

    task automatic test_backpressure();
        logic [7:0] q [$];
        logic [7:0] d;
        logic [7:0] rxb;
        logic       stop_lvl;
        bit         ovf;
        bit         found;
        bit         saw_low;
        // All-ones priming byte keeps the in-flight frame high after its start bit
        store(A_BASE, 8'hFF);
        repeat (2) tick();
        ovf = 1'b0;
        for (int k = 0; k < 17; k++) begin
            d = 8'($urandom);
            store(A_BASE, d);
            if (q.size() < 16) q.push_back(d);
            else               ovf = 1'b1;
            tick();
            checks++;
            if (io_buffer_full !== (q.size() >= 15)) begin
                failures++;
                $display("FAIL bp_buf_full stores=%0d got=%b exp=%b", k + 1, io_buffer_full, (q.size() >= 15));
            end
            checks++;
            if (tx_overflow !== ovf) begin
                failures++;
                $display("FAIL bp_overflow stores=%0d got=%b exp=%b", k + 1, tx_overflow, ovf);
            end
        end
        while (q.size() > 0) begin
            d = q.pop_front();
            uart_rx(rxb, found, stop_lvl);
            checks++;
            if (!found || rxb !== d || stop_lvl !== 1'b1) begin
                failures++;
                $display("FAIL bp_drain found=%0d got=%h stop=%b exp=%h stop=1", found, rxb, stop_lvl, d);
            end
        end
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (uart_txd !== 1'b1) saw_low = 1'b1;
            tick();
        end
        checks++; if (saw_low) begin failures++; $display("FAIL bp_dropped_byte got=extra_frame exp=idle"); end
    endtask

    task automatic test_halt_reset();
        bit saw_low;
        store(A_OTHER, 8'h11);
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL halt_other_store got=%b exp=0", halt); end
        store(A_HALT, 8'h01);
        checks++; if (halt !== 1'b1) begin failures++; $display("FAIL halt_set got=%b exp=1", halt); end
        mem_a = A_BASE; mem_wr = 1'b1;
        for (int k = 0; k < 18; k++) begin
            mem_din = 8'($urandom);
            tick();
        end
        mem_wr = 1'b0; mem_a = 32'h0;
        tick();
        checks++; if (io_buffer_full !== 1'b1) begin failures++; $display("FAIL pre_reset_buf_full got=%b exp=1", io_buffer_full); end
        checks++; if (tx_overflow !== 1'b1) begin failures++; $display("FAIL pre_reset_overflow got=%b exp=1", tx_overflow); end
        rst = 1'b1;
        tick();
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL rst_halt got=%b exp=0", halt); end
        checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL rst_txd got=%b exp=1", uart_txd); end
        checks++; if (io_buffer_full !== 1'b0) begin failures++; $display("FAIL rst_buf_full got=%b exp=0", io_buffer_full); end
        checks++; if (tx_overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", tx_overflow); end
        rst = 1'b0;
        saw_low = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (uart_txd !== 1'b1) saw_low = 1'b1;
            tick();
        end
        checks++; if (saw_low) begin failures++; $display("FAIL rst_fifo_discard got=frame exp=idle"); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_uart_frame();
        test_rdy_freeze();
        test_rx();
        test_backpressure();
        test_halt_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
